ps2_receiver: RTL

PS/2 device-to-host receive stage, the counterpart of the transmit shifter. It sits between the raw PS/2 pins and the keyboard/scan-code decoder. It synchronizes and de-glitches the PS/2 clock, samples data on PS/2 clock falling edges, assembles 11-bit frames (start, 8 data LSB-first, odd parity, stop), checks them and hands good bytes to the consumer with a valid/ack handshake.

---
 rtl/ps2_receiver.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: pin sync, clock de-glitch, 11-bit frame capture, valid/ack hand-off.
// Optional partial-frame watchdog is enabled with `define PS2_RX_TIMEOUT_EN.
//
//   state  | meaning
//   IDLE   | waiting for a start bit (data low on a filtered clock fall)
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | capturing the odd-parity bit
//   STOP   | checking the stop bit and parity, then delivering or flagging
module ps2_receiver #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       Resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [7:0] FLT_LAST = 8'(FILTER_LEN - 1);

  state_t     state, state_next;
  logic       clk_s1, clk_s2, dat_s1, dat_s2;
  logic [7:0] flt_cnt;
  logic       f_clk, f_clk_q, fall;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic       par_bit;
  logic       expire;
  logic       deliver_s, perr_s, ferr_s;

  // Bus idles high, so the synchronizers come out of reset at 1.
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // f_clk follows the synced clock only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      flt_cnt <= '0;
      f_clk   <= 1'b1;
      f_clk_q <= 1'b1;
    end else begin
      f_clk_q <= f_clk;
      if (clk_s2 == f_clk) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        flt_cnt <= '0;
        f_clk   <= clk_s2;
      end else begin
        flt_cnt <= flt_cnt + 8'd1;
      end
    end
  end

  assign fall = f_clk_q & ~f_clk;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;

  // Expiry is decided one count early so the pulse lands on the edge the count hits TIMEOUT_CYCLES.
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      wd_cnt <= '0;
    end else if (fall || state == IDLE || expire) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign expire = (state != IDLE) && !fall && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= expire;
    end
  end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;

  if (TIMEOUT_CYCLES < 1) begin : g_no_watchdog
  end
`endif

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (expire) begin
      state_next = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!dat_s2) state_next = DATA;
        DATA:    if (bit_cnt == 4'd7) state_next = PARITY;
        PARITY:  state_next = STOP;
        STOP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else if (expire) begin
      bit_cnt <= '0;
    end else if (fall) begin
      case (state)
        IDLE: bit_cnt <= '0;
        DATA: begin
          shreg   <= {dat_s2, shreg[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
        PARITY:  par_bit <= dat_s2;
        default: ;
      endcase
    end
  end

  // A bad stop bit outranks a parity error.
  always_comb begin
    deliver_s = 1'b0;
    perr_s    = 1'b0;
    ferr_s    = 1'b0;
    if (fall && state == STOP) begin
      if (!dat_s2) begin
        ferr_s = 1'b1;
      end else if (!(^{shreg, par_bit})) begin
        perr_s = 1'b1;
      end else begin
        deliver_s = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= perr_s;
      frame_err  <= ferr_s;
      overrun    <= 1'b0;
      if (deliver_s && (!rx_valid || rx_ack)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (deliver_s) begin
        overrun <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
